// File: rtl/img_bram_arbiter_if.sv
// Requester-side bus of the img_storage read arbiter: two request/address
// pairs in, grants and tagged read data out.
interface img_bram_arbiter_if;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          err;

  // Requester view
  modport master (
    output req0, req1, addr0, addr1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, err
  );

  // Arbiter view
  modport slave (
    input  req0, req1, addr0, addr1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, err
  );
endinterface

// File: rtl/img_bram_arbiter.sv
// Round-robin, burst-bounded arbiter for the single read port of img_storage.
// Grants are same-cycle; each grant returns one tagged beat RD_LAT+1 cycles later.
module img_bram_arbiter #(
  parameter int unsigned DEPTH     = 10000,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  img_bram_arbiter_if.slave   bus_if,
  output logic [13:0]         bram_addr_o,
  output logic                bram_we_o,
  input  logic [7:0]          bram_dout_i
);
  localparam int unsigned AW   = 14;
  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned PIPE = RD_LAT + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            burst_ok;
  logic            gnt0_c, gnt1_c;
  logic            grant;
  logic [AW-1:0]   gnt_addr;
  logic            gnt_oor;
  logic [AW-1:0]   bram_addr_q;
  logic            err_q;
  logic [PIPE-1:0] vld_q;
  logic [PIPE-1:0] port_q;
  logic [PIPE-1:0] oor_q;

  assign burst_ok = (cnt_q < CW'(MAX_BURST));
  assign cnt_inc  = burst_ok ? cnt_q + CW'(1) : cnt_q;

  // Arbitration state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and same-cycle grant decision; grants are suppressed during reset
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus_if.req0 && (!bus_if.req1 || last_q)) begin
            gnt0_c = 1'b1; state_d = OWN0; cnt_d = CW'(1); last_d = 1'b0;
          end else if (bus_if.req1) begin
            gnt1_c = 1'b1; state_d = OWN1; cnt_d = CW'(1); last_d = 1'b1;
          end
        end
        OWN0: begin
          if (bus_if.req0 && (burst_ok || !bus_if.req1)) begin
            gnt0_c = 1'b1; cnt_d = cnt_inc;
          end else if (bus_if.req1) begin
            gnt1_c = 1'b1; state_d = OWN1; cnt_d = CW'(1); last_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        OWN1: begin
          if (bus_if.req1 && (burst_ok || !bus_if.req0)) begin
            gnt1_c = 1'b1; cnt_d = cnt_inc;
          end else if (bus_if.req0) begin
            gnt0_c = 1'b1; state_d = OWN0; cnt_d = CW'(1); last_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign grant    = gnt0_c | gnt1_c;
  assign gnt_addr = gnt1_c ? bus_if.addr1 : bus_if.addr0;
  assign gnt_oor  = ({1'b0, gnt_addr} >= (AW+1)'(DEPTH));

  // Address register, sticky error flag and read-return tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_addr_q <= '0;
      err_q       <= 1'b0;
      vld_q       <= '0;
      port_q      <= '0;
      oor_q       <= '0;
    end else begin
      if (grant) begin
        bram_addr_q <= gnt_addr;
      end
      if (grant && gnt_oor) begin
        err_q <= 1'b1;
      end
      vld_q  <= {vld_q[PIPE-2:0], grant};
      port_q <= {port_q[PIPE-2:0], gnt1_c};
      oor_q  <= {oor_q[PIPE-2:0], gnt_oor};
    end
  end

  assign bus_if.gnt0    = gnt0_c;
  assign bus_if.gnt1    = gnt1_c;
  assign bus_if.rvalid0 = vld_q[PIPE-1] & ~port_q[PIPE-1];
  assign bus_if.rvalid1 = vld_q[PIPE-1] &  port_q[PIPE-1];
  assign bus_if.rdata   = (vld_q[PIPE-1] && !oor_q[PIPE-1]) ? bram_dout_i : DW'(0);
  assign bus_if.err     = err_q;
  assign bram_addr_o    = bram_addr_q;
  assign bram_we_o      = 1'b0;
endmodule

// File: doc/img_bram_arbiter.md
# img_bram_arbiter

Arbitrates the single read port of the `img_storage` block RAM (10000 × 8-bit, 14-bit address) between two read requesters: port 0, the window fetcher that feeds the 3×3 filter datapath, and port 1, the display/readback path. Arbitration is round-robin with bounded bursts, so a streaming requester keeps row locality without starving the other. The block sits directly in front of `img_storage`, drives its address and write enable, and returns tagged read data to the winning requester after the fixed BRAM latency.

## Interface
- `DEPTH`, 10000: number of valid image addresses (100 × 100).
- `RD_LAT`, 1: BRAM read latency in cycles, from address to `douta`. Must be 1 or 2.
- `MAX_BURST`, 8: maximum consecutive grants to one owner while the other port is requesting. Must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req0` / `req1` in 1: read request from port 0 / port 1; held until granted.
- `addr0` / `addr1` in 14: read address for port 0 / port 1; valid while the matching req is high.
- `gnt0` / `gnt1` out 1: request accepted in this cycle. Combinational from the current state and the req inputs.
- `rvalid0` / `rvalid1` out 1: `rdata` belongs to port 0 / port 1 in this cycle.
- `rdata` out 8: read data, shared by both ports.
- `err` out 1: sticky flag. Set when an address ≥ `DEPTH` is accepted. Cleared only by `rst`.
- `bram_addr` out 14: to `img_storage.addra`.
- `bram_we` out 1: to `img_storage.wea`. Constant 0.
- `bram_dout` in 8: from `img_storage.douta`.

## Operation
- The arbiter has three states: `IDLE`, `OWN0` and `OWN1`. It also holds a round-robin pointer `last` (the most recently served port) and a burst counter `cnt` (4 bits, saturating at `MAX_BURST`).
- **In `IDLE`:**
  - If only one port requests, grant it.
  - If both request, grant the port that is not `last`.
  - The grant goes to the winner in the same cycle. Next state is `OWNx`, with `cnt` = 1 and `last` = x.
- **In `OWNx`, where y is the other port:**
  - If `reqx` is high and (`cnt` < `MAX_BURST` or `reqy` is low): grant x and increment `cnt` (saturating).
  - Otherwise, if `reqy` is high: grant y in this cycle. Next state is `OWNy`, with `cnt` = 1 and `last` = y.
  - Otherwise: no grant, and next state is `IDLE`.
- At most one of `gnt0` / `gnt1` is high in any cycle.
- Ownership hands over with no idle cycle in between.
- `bram_addr`:
  - Equals the address of the port being granted in this cycle.
  - When there is no grant, it holds its previous value.
  - It is registered, so the BRAM sees the address on the following edge.
- Read-return pipeline:
  - A tag {valid, port, oor} enters a shift register of depth `RD_LAT` + 1 when a grant occurs. The extra stage covers the address register.
  - At the output of the pipeline, `rvalid0` or `rvalid1` is asserted according to the tag's port.
  - `rdata` = `bram_dout`, or 8'h00 when the tag's oor bit is set.
  - When no tag is valid, `rdata` = 0.
- Out-of-range requests:
  - An accepted address ≥ `DEPTH` is still granted and still returns a beat, with data 0.
  - `err` is set on the cycle after acceptance.
- Requests are never dropped. Each grant produces exactly one `rvalid` beat, in grant order.

## Timing
- **Reset values:** `gnt0`/`gnt1` = 0, because the state is `IDLE` and no request is visible until after reset. Also `rvalid0`/`rvalid1` = 0, `rdata` = 0, `err` = 0, `bram_addr` = 0, `bram_we` = 0.
- **Reset internals:** state = `IDLE`, `last` = 1 (so port 0 wins the first tie), `cnt` = 0, and all pipeline tags are cleared.
- **Grant latency:** 0 cycles, in the same cycle as the request.
- **Read latency:** `rvalid` asserts `RD_LAT` + 1 cycles after the grant cycle. That is 2 cycles at the default setting.
- **Throughput:** one grant per cycle sustained, with or without port switches.
- **`rst` asserted mid-operation:**
  - All in-flight tags are discarded, and no `rvalid` appears for grants accepted before reset.
  - `gnt` outputs are forced low during the reset cycle regardless of req.
- **Both requests rising in the same cycle from `IDLE`:** resolved by `last` only.
- **Owner drops req on the cycle its burst expires:** if the other port is requesting, it is granted in that cycle.
- **`MAX_BURST` = 1:** strict alternation whenever both ports are requesting.

## Test plan
- **Single port stream:** after reset, `req0` is held for 5 cycles with `addr0` = 0,1,2,3,4 and `req1` = 0. Required: `gnt0` is high for 5 consecutive cycles, and `rvalid0` pulses 2 cycles later with `rdata` = mem[0..4] in order. `gnt1` and `rvalid1` stay 0.
- **Tie after reset:** `req0` = `req1` = 1 on the first cycle after reset. Required: `gnt0` is first. Port 0 then holds for exactly 8 grants, `gnt1` follows in the 9th cycle with no gap, and port 1 holds for 8 grants.
- **Handover without bubble:** port 1 owns the bus and drops `req1` while `req0` is high. Required: `gnt0` asserts in the same cycle, and `rvalid` beats are contiguous with the port tags switching.
- **Out of range:** `req1` with `addr1` = 10000. Required: `gnt1` = 1, and 2 cycles later `rvalid1` = 1 with `rdata` = 8'h00. `err` = 1 from the cycle after the grant, and it stays 1 until `rst`.
- **Reset mid-burst:** issue 3 port-0 grants, then assert `rst` for one cycle. Required: no `rvalid0` after the reset edge, all outputs at their reset values, and the next tie is won by port 0.
- **`MAX_BURST` = 1 build:** both ports continuously requesting. Required: grants alternate 0,1,0,1 every cycle, and each beat returns 2 cycles later to the matching port.
